prog_clk_div: RTL

//  Runtime-programmable integer clock divider; upstream companion of the fixed /2,/4,/8 divider.

---
 rtl/prog_clk_div.sv | 119 +++++++++++
 1 files changed

// File: rtl/prog_clk_div.sv
// prog_clk_div: runtime-programmable integer clock divider.
// Produces a glitch-free divided clock (clk_out) and a one-cycle enable strobe
// (clk_en) in the clk_in domain. A new ratio is loaded via a req/ack handshake
// and only takes effect at the next period boundary.
//
// Ports:
//   clk_in    in   1  single clock, all logic on posedge
//   rst       in   1  asynchronous active-low reset
//   div_req   in   1  ratio load request (level, held until div_ack)
//   div_val   in   W  requested ratio, stable while div_req=1
//   div_ack   out  1  one-cycle pulse: request consumed
//   div_err   out  1  one-cycle pulse with div_ack: ratio < 2, discarded
//   div_busy  out  1  accepted ratio waiting for the period boundary
//   cur_div   out  W  ratio currently in effect
//   clk_out   out  1  divided clock (registered)
//   clk_en    out  1  strobe on the first clk_in cycle of each clk_out period
module prog_clk_div #(
  parameter int unsigned W       = 8,
  parameter int unsigned DEF_DIV = 4
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         div_req,
  input  logic [W-1:0] div_val,
  output logic         div_ack,
  output logic         div_err,
  output logic         div_busy,
  output logic [W-1:0] cur_div,
  output logic         clk_out,
  output logic         clk_en
);

  localparam logic [W-1:0] DEF_DIV_W = W'(DEF_DIV);
  localparam logic [W-1:0] ONE_W     = W'(1);
  localparam logic [W-1:0] TWO_W     = W'(2);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] cur_div_q, cur_div_d;
  logic [W-1:0] pend_q, pend_d;
  logic         busy_q, busy_d;
  logic         ack_q, ack_d;
  logic         err_q, err_d;
  logic         clk_out_q, clk_out_d;
  logic         clk_en_q, clk_en_d;

  logic last_c;
  logic apply_c;
  logic accept_c;
  logic valid_c;

  // Next-state: counter wrap, ratio apply at boundary, handshake acceptance.
  always_comb begin
    cnt_d     = cnt_q;
    cur_div_d = cur_div_q;
    pend_d    = pend_q;
    busy_d    = busy_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;

    last_c   = (cnt_q == (cur_div_q - ONE_W));
    apply_c  = last_c && busy_q;
    // ack_q guard stops a still-high request from being taken twice.
    accept_c = div_req && !busy_q && !ack_q;
    valid_c  = (div_val >= TWO_W);

    cnt_d = last_c ? '0 : (cnt_q + ONE_W);

    if (apply_c) begin
      cur_div_d = pend_q;
      busy_d    = 1'b0;
    end

    // accept_c needs busy_q=0 and apply_c needs busy_q=1, so they never collide.
    if (accept_c) begin
      ack_d = 1'b1;
      if (valid_c) begin
        pend_d = div_val;
        busy_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    // Outputs follow the next counter value and the ratio for that period.
    clk_out_d = (cnt_d < (cur_div_d >> 1));
    clk_en_d  = (cnt_d == '0);
  end

  // State and output registers.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      cnt_q     <= DEF_DIV_W - ONE_W;
      cur_div_q <= DEF_DIV_W;
      pend_q    <= '0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      clk_out_q <= 1'b0;
      clk_en_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      cur_div_q <= cur_div_d;
      pend_q    <= pend_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      clk_out_q <= clk_out_d;
      clk_en_q  <= clk_en_d;
    end
  end

  assign div_ack  = ack_q;
  assign div_err  = err_q;
  assign div_busy = busy_q;
  assign cur_div  = cur_div_q;
  assign clk_out  = clk_out_q;
  assign clk_en   = clk_en_q;

endmodule
